// File: rtl/uart_core.sv
// Full-duplex 8N1 UART with independent TX/RX channels, runtime clocks-per-bit divisors
// and byte-wide valid/ready handshakes on both sides.
module uart_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_data_vld_i,
  output logic        tx_data_rdy_o,
  input  logic [31:0] tx_baud_div_i,
  output logic        tx_o,
  input  logic        rx_i,
  input  logic        rx_data_rdy_i,
  input  logic [31:0] rx_baud_div_i,
  output logic        rx_data_vld_o,
  output logic [7:0]  rx_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e      tx_state_q, tx_state_d;
  logic [31:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, tx_div_eff;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;

  state_e      rx_state_q, rx_state_d;
  logic [31:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_div_eff;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_vld_q, rx_vld_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic        rx_prev_q, rx_s;

  // Divisors below 2 would leave no room for a mid-bit sample, so clamp them.
  assign tx_div_eff = (tx_baud_div_i < 32'd2) ? 32'd2 : tx_baud_div_i;
  assign rx_div_eff = (rx_baud_div_i < 32'd2) ? 32'd2 : rx_baud_div_i;
  assign rx_s       = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q  <= rx_s;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_data_vld_i) begin
          tx_shift_d = tx_data_i;
          tx_div_d   = tx_div_eff;
          tx_cnt_d   = tx_div_eff - 32'd1;
          tx_d       = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 32'd0) begin
          tx_cnt_d   = tx_div_q - 32'd1;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 32'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 32'd0) begin
          tx_cnt_d = tx_div_q - 32'd1;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 32'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 32'd0) tx_state_d = S_IDLE;
        else                   tx_cnt_d   = tx_cnt_q - 32'd1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_vld_d   = rx_vld_q;
    if (rx_vld_q && rx_data_rdy_i) rx_vld_d = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_div_d   = rx_div_eff;
          rx_cnt_d   = (rx_div_eff >> 1) - 32'd1;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == 32'd0) begin
          if (rx_s) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_cnt_d   = rx_div_q - 32'd1;
            rx_bit_d   = 3'd0;
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 32'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 32'd0) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 32'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 32'd1;
        end
      end
      S_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (rx_cnt_q == 32'd0) begin
          rx_state_d = S_IDLE;
          if (rx_s) begin
            rx_data_d = rx_shift_q;
            rx_vld_d  = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 32'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign tx_data_rdy_o = (tx_state_q == S_IDLE);
  assign tx_o          = tx_q;
  assign rx_data_vld_o = rx_vld_q;
  assign rx_data_o     = rx_data_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: received bytes are checked by a scoreboard monitor,
// transmit waveforms and handshake timing are checked against hand-built frames.
module tb_uart_core;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  tx_data_i = '0;
  logic        tx_data_vld_i = 1'b0;
  logic        tx_data_rdy_o;
  logic [31:0] tx_baud_div_i = 32'd100;
  logic        tx_o;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;
  logic        rx_data_rdy_i = 1'b1;
  logic [31:0] rx_baud_div_i = 32'd100;
  logic        rx_data_vld_o;
  logic [7:0]  rx_data_o;

  int n_cmp = 0;
  int n_err = 0;
  int vld_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx_o : rx_drv;

  uart_core #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tx_data_i(tx_data_i), .tx_data_vld_i(tx_data_vld_i), .tx_data_rdy_o(tx_data_rdy_o),
    .tx_baud_div_i(tx_baud_div_i), .tx_o(tx_o),
    .rx_i(rx_line), .rx_data_rdy_i(rx_data_rdy_i), .rx_baud_div_i(rx_baud_div_i),
    .rx_data_vld_o(rx_data_vld_o), .rx_data_o(rx_data_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every consumed byte must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && rx_data_vld_o && rx_data_rdy_i) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got byte %0h, expected none", rx_data_o);
        end else begin
          chk("rx_byte", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_sb(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drain", exp_q.size(), 0);
  endtask

  task automatic handshake(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    tx_data_i = b;
    tx_data_vld_i = 1'b1;
    while (!tx_data_rdy_o && k < 30000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30000) chk("tx_rdy_wait", 32'(tx_data_rdy_o), 1);
    @(posedge clk);
    #1 tx_data_vld_i = 1'b0;
  endtask

  // Sends one byte and checks every clock of the serial frame plus rdy timing.
  task automatic tx_frame(input logic [7:0] b, input logic [31:0] div_in, input int eff,
                          input int chg_at, input logic [31:0] new_div);
    logic [9:0] frame;
    int bad = 0;
    int low = 0;
    frame = {1'b1, b, 1'b0};
    tx_baud_div_i = div_in;
    handshake(b);
    for (int k = 0; k < 10 * eff; k++) begin
      @(negedge clk);
      if (k == chg_at) tx_baud_div_i = new_div;
      if (tx_o !== frame[k / eff]) bad++;
      if (!tx_data_rdy_o) low++;
    end
    @(negedge clk);
    chk("tx_bits_bad", bad, 0);
    chk("tx_rdy_low_clks", low, 10 * eff);
    chk("tx_rdy_back", 32'(tx_data_rdy_o), 1);
    chk("tx_idle_high", 32'(tx_o), 1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (div) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (div) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_o", 32'(tx_o), 1);
    chk("rst_tx_rdy", 32'(tx_data_rdy_o), 1);
    chk("rst_rx_vld", 32'(rx_data_vld_o), 0);
    chk("rst_rx_data", 32'(rx_data_o), 0);
    rst_i = 1'b0;

    // 1: single frame 0x61 at div 100
    tx_frame(8'h61, 32'd100, 100, -1, 32'd0);

    // 2: loopback, incrementing source
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h61 + 8'(i));
      handshake(8'h61 + 8'(i));
    end
    wait_sb(3000);
    chk("loop_count", vld_cnt, 4);

    // 3: glitch and framing error, then a good frame
    loop_en = 1'b0;
    saved = vld_cnt;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (30) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_vld", vld_cnt, saved);
    drive_frame(8'hA5, 1'b0, 100);
    repeat (200) @(negedge clk);
    chk("framing_no_vld", vld_cnt, saved);
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1, 100);
    wait_sb(500);

    // 4: overrun with consumer stalled
    rx_data_rdy_i = 1'b0;
    drive_frame(8'h11, 1'b1, 100);
    chk("stall_vld1", 32'(rx_data_vld_o), 1);
    chk("stall_data1", 32'(rx_data_o), 32'h11);
    drive_frame(8'h22, 1'b1, 100);
    chk("overrun_vld", 32'(rx_data_vld_o), 1);
    chk("overrun_data", 32'(rx_data_o), 32'h22);
    exp_q.push_back(8'h22);
    @(posedge clk);
    #1 rx_data_rdy_i = 1'b1;
    wait_sb(20);
    repeat (2) @(negedge clk);
    chk("consumed_vld", 32'(rx_data_vld_o), 0);

    // 5: reset mid-frame on both channels
    loop_en = 1'b1;
    tx_baud_div_i = 32'd100;
    handshake(8'hF0);
    repeat (350) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_tx_o", 32'(tx_o), 1);
    chk("midrst_tx_rdy", 32'(tx_data_rdy_o), 1);
    chk("midrst_rx_data", 32'(rx_data_o), 0);
    saved = vld_cnt;
    repeat (1200) @(negedge clk);
    chk("midrst_rx_no_vld", vld_cnt, saved);

    // 6: divisor clamp and mid-frame divisor change
    rx_baud_div_i = 32'd1;
    exp_q.push_back(8'h5A);
    tx_frame(8'h5A, 32'd0, 2, -1, 32'd0);
    wait_sb(40);
    rx_baud_div_i = 32'd0;
    exp_q.push_back(8'hA5);
    tx_frame(8'hA5, 32'd1, 2, -1, 32'd0);
    wait_sb(40);
    rx_baud_div_i = 32'd100;
    exp_q.push_back(8'hC3);
    tx_frame(8'hC3, 32'd100, 100, 5, 32'd3);
    wait_sb(300);

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
